// File: rtl/apu_mix_pkg.sv
// Shared constants and elaboration-time generators for the APU mixer curve tables.
package apu_mix_pkg;

  localparam int PULSE_IDX_MAX = 30;
  localparam int TND_IDX_MAX   = 202;
  localparam int VOL_UNITY     = 16;

  // 95.52/(8128/n+100) rewritten as 9552*n/(812800+10000*n), rounded half-up in integers.
  function automatic int pulse_lut_val(input int n, input int lut_w);
    longint fs, num, den;
    fs  = (longint'(1) << lut_w) - 1;
    num = longint'(9552) * longint'(n) * fs;
    den = longint'(812800) + longint'(10000) * longint'(n);
    return int'((2 * num + den) / (2 * den));
  endfunction

  // 163.67/(24329/n+100) rewritten as 16367*n/(2432900+10000*n).
  function automatic int tnd_lut_val(input int n, input int lut_w);
    longint fs, num, den;
    fs  = (longint'(1) << lut_w) - 1;
    num = longint'(16367) * longint'(n) * fs;
    den = longint'(2432900) + longint'(10000) * longint'(n);
    return int'((2 * num + den) / (2 * den));
  endfunction

  function automatic logic [4:0] vol_step(input logic [4:0] cur, input logic [4:0] tgt);
    if (cur < tgt) return cur + 5'd1;
    if (cur > tgt) return cur - 5'd1;
    return cur;
  endfunction

endpackage

// File: rtl/apu_mix_hpf.sv
// DC-blocking first-order high-pass stage: y = x - x_prev + y_prev - (y_prev >>> HPF_K).
module apu_mix_hpf #(
  parameter int OUT_W = 16,
  parameter int HPF_K = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  input  logic [OUT_W-1:0] in_sample,
  output logic [OUT_W-1:0] out_sample,
  output logic             out_valid
);
  localparam int ACC_W = OUT_W + 2;
  localparam logic signed [ACC_W-1:0] SAT_MAX = ACC_W'((longint'(1) << (OUT_W - 1)) - 1);
  localparam logic signed [ACC_W-1:0] SAT_MIN = -SAT_MAX - 1;

  logic signed [ACC_W-1:0] x_cur;
  logic signed [ACC_W-1:0] x_prev_reg;
  logic signed [ACC_W-1:0] y_prev_reg;
  logic signed [ACC_W-1:0] y_next;
  logic [OUT_W-1:0]        y_sat;

  // Input is unsigned, so it enters the signed accumulator with zero MSBs.
  assign x_cur  = signed'({2'b00, in_sample});
  assign y_next = x_cur - x_prev_reg + y_prev_reg - (y_prev_reg >>> HPF_K);

  always_comb begin
    y_sat = y_next[OUT_W-1:0];
    if (y_next > SAT_MAX)
      y_sat = {1'b0, {(OUT_W-1){1'b1}}};
    else if (y_next < SAT_MIN)
      y_sat = {1'b1, {(OUT_W-1){1'b0}}};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      x_prev_reg <= '0;
      y_prev_reg <= '0;
      out_sample <= '0;
      out_valid  <= 1'b0;
    end else begin
      out_valid <= in_valid;
      if (in_valid) begin
        x_prev_reg <= x_cur;
        y_prev_reg <= y_next;
        out_sample <= y_sat;
      end
    end
  end

endmodule

// File: rtl/apu_mixer_pipe.sv
// APU output mixer: channel sums -> nonlinear curve LUTs -> ramped master volume.
// Define APU_MIXER_HPF_EN to append the DC-blocking high-pass stage (adds one cycle).
module apu_mixer_pipe #(
  parameter int LUT_W = 12,
  parameter int OUT_W = 16,
  parameter int HPF_K = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             sample_en,
  input  logic [3:0]       square_1_in,
  input  logic [3:0]       square_2_in,
  input  logic [3:0]       triangle_in,
  input  logic [3:0]       noise_in,
  input  logic [6:0]       dmc_in,
  input  logic [4:0]       volume,
  output logic [OUT_W-1:0] mixer_out,
  output logic             mixer_valid
);
  import apu_mix_pkg::*;

  if (OUT_W < LUT_W + 1 || HPF_K < 1) begin : g_bad_param
    $error("apu_mixer_pipe: OUT_W must be >= LUT_W+1 and HPF_K >= 1");
  end

  logic [4:0]       pulse_sum, pulse_idx_reg;
  logic [7:0]       tnd_sum, tnd_idx_reg;
  logic [4:0]       vol_tgt, vol_next, vol_cur_reg, vol_s1_reg, vol_s2_reg;
  logic             s1_valid_reg, s2_valid_reg, s3_valid_reg;
  logic [LUT_W-1:0] p_reg, t_reg, mix_sat;
  logic [LUT_W:0]   mix_sum;
  logic [LUT_W+4:0] product;
  logic [OUT_W-1:0] s3_out, s3_out_reg;

  logic [LUT_W-1:0] pulse_rom [PULSE_IDX_MAX+1];
  logic [LUT_W-1:0] tnd_rom   [TND_IDX_MAX+1];

  genvar gi;
  for (gi = 0; gi <= PULSE_IDX_MAX; gi++) begin : g_pulse_rom
    localparam int ENTRY = pulse_lut_val(gi, LUT_W);
    assign pulse_rom[gi] = LUT_W'(ENTRY);
  end
  for (gi = 0; gi <= TND_IDX_MAX; gi++) begin : g_tnd_rom
    localparam int ENTRY = tnd_lut_val(gi, LUT_W);
    assign tnd_rom[gi] = LUT_W'(ENTRY);
  end

  assign pulse_sum = {1'b0, square_1_in} + {1'b0, square_2_in};
  assign tnd_sum   = {3'b000, triangle_in, 1'b0} + {4'b0000, triangle_in}
                   + {3'b000, noise_in, 1'b0} + {1'b0, dmc_in};

  assign vol_tgt  = (volume > 5'(VOL_UNITY)) ? 5'(VOL_UNITY) : volume;
  assign vol_next = vol_step(vol_cur_reg, vol_tgt);

  assign mix_sum = {1'b0, p_reg} + {1'b0, t_reg};
  assign mix_sat = mix_sum[LUT_W] ? '1 : mix_sum[LUT_W-1:0];
  assign product = mix_sat * vol_s2_reg;
  assign s3_out  = OUT_W'(product >> 4) << (OUT_W - LUT_W);

  // Each sample carries the volume in effect before its own ramp step.
  always_ff @(posedge clk) begin
    if (reset) begin
      s1_valid_reg <= 1'b0;
      s2_valid_reg <= 1'b0;
      s3_valid_reg <= 1'b0;
      s3_out_reg   <= '0;
      vol_cur_reg  <= '0;
    end else begin
      s1_valid_reg <= sample_en;
      if (sample_en) begin
        pulse_idx_reg <= pulse_sum;
        tnd_idx_reg   <= tnd_sum;
        vol_s1_reg    <= vol_cur_reg;
        vol_cur_reg   <= vol_next;
      end
      s2_valid_reg <= s1_valid_reg;
      if (s1_valid_reg) begin
        p_reg      <= pulse_rom[pulse_idx_reg];
        t_reg      <= tnd_rom[tnd_idx_reg];
        vol_s2_reg <= vol_s1_reg;
      end
      s3_valid_reg <= s2_valid_reg;
      if (s2_valid_reg)
        s3_out_reg <= s3_out;
    end
  end

`ifdef APU_MIXER_HPF_EN
  apu_mix_hpf #(
    .OUT_W(OUT_W),
    .HPF_K(HPF_K)
  ) u_hpf (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (s3_valid_reg),
    .in_sample (s3_out_reg),
    .out_sample(mixer_out),
    .out_valid (mixer_valid)
  );
`else
  assign mixer_out   = s3_out_reg;
  assign mixer_valid = s3_valid_reg;
`endif

endmodule

// File: tb/tb_apu_mixer_pipe.sv
// Directed bench for apu_mixer_pipe: spec-level model checked every cycle plus literal pins.
module tb_apu_mixer_pipe;
  localparam int LUT_W = 12;
  localparam int OUT_W = 16;
  localparam int HPF_K = 8;
`ifdef APU_MIXER_HPF_EN
  localparam int LAT = 4;
`else
  localparam int LAT = 3;
`endif
  localparam int MAXC = 4096;

  logic        clk = 1'b0;
  logic        reset, sample_en;
  logic [3:0]  square_1_in, square_2_in, triangle_in, noise_in;
  logic [6:0]  dmc_in;
  logic [4:0]  volume;
  logic [15:0] mixer_out;
  logic        mixer_valid;

  int total = 0;
  int bad   = 0;

  apu_mixer_pipe #(.LUT_W(LUT_W), .OUT_W(OUT_W), .HPF_K(HPF_K)) dut (
    .clk        (clk),
    .reset      (reset),
    .sample_en  (sample_en),
    .square_1_in(square_1_in),
    .square_2_in(square_2_in),
    .triangle_in(triangle_in),
    .noise_in   (noise_in),
    .dmc_in     (dmc_in),
    .volume     (volume),
    .mixer_out  (mixer_out),
    .mixer_valid(mixer_valid)
  );

  always #5 clk = ~clk;

  task automatic check(input string nm, input longint got, input longint want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got=%0d want=%0d", nm, got, want);
    end
  endtask

  // Curve tables straight from the real-valued NES formulas.
  function automatic int lut_p(input int n);
    real v;
    if (n == 0) return 0;
    v = 95.52 / (8128.0 / n + 100.0) * real'((1 << LUT_W) - 1);
    return $rtoi(v + 0.5);
  endfunction

  function automatic int lut_t(input int n);
    real v;
    if (n == 0) return 0;
    v = 163.67 / (24329.0 / n + 100.0) * real'((1 << LUT_W) - 1);
    return $rtoi(v + 0.5);
  endfunction

  // Model: per posedge, schedule the expected output at the cycle it must appear.
  int          cyc = 0;
  bit          exp_v  [MAXC];
  bit          rst_at [MAXC];
  logic [15:0] exp_o  [MAXC];
  int          m_vol = 0;
  longint      hx = 0, hy = 0;

  always @(posedge clk) begin
    int tgt, mix, x;
    longint y;
    cyc = cyc + 1;
    if (reset) begin
      rst_at[cyc] = 1'b1;
      for (int k = 0; k <= LAT; k++) exp_v[cyc + k] = 1'b0;
      m_vol = 0;
      hx = 0;
      hy = 0;
    end else if (sample_en) begin
      tgt = (volume > 16) ? 16 : int'(volume);
      mix = lut_p(square_1_in + square_2_in) + lut_t(3 * triangle_in + 2 * noise_in + dmc_in);
      if (mix > (1 << LUT_W) - 1) mix = (1 << LUT_W) - 1;
      x = ((mix * m_vol) / 16) * (1 << (OUT_W - LUT_W));
      if (m_vol < tgt) m_vol++;
      else if (m_vol > tgt) m_vol--;
`ifdef APU_MIXER_HPF_EN
      y  = longint'(x) - hx + hy - (hy >>> HPF_K);
      hx = x;
      hy = y;
      if (y > 32767) y = 32767;
      if (y < -32768) y = -32768;
      exp_o[cyc + LAT - 1] = 16'(y);
`else
      exp_o[cyc + LAT - 1] = 16'(x);
`endif
      exp_v[cyc + LAT - 1] = 1'b1;
    end
  end

  logic [15:0] held = '0;
  logic [15:0] got_q [$];

  always @(negedge clk) begin
    bit ev;
    if (cyc > 0) begin
      ev = 1'b0;
      if (rst_at[cyc]) held = '0;
      else if (exp_v[cyc]) begin
        ev   = 1'b1;
        held = exp_o[cyc];
      end
      check("valid_strobe", mixer_valid, ev);
      check("out_value", mixer_out, held);
      if (mixer_valid === 1'b1) begin
        got_q.push_back(mixer_out);
        $display("txn cyc=%0d out=%0d", cyc, mixer_out);
      end
    end
  end

  function automatic longint got_at(input int i);
    if (i < 0 || i >= got_q.size()) return -1;
    return longint'(got_q[i]);
  endfunction

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic run_samples(input int n);
    sample_en = 1'b1;
    repeat (n) @(negedge clk);
    sample_en = 1'b0;
  endtask

  task automatic set_levels(input int sq, input int tri_l, input int noi, input int dmc);
    square_1_in = 4'(sq);
    square_2_in = 4'(sq);
    triangle_in = 4'(tri_l);
    noise_in    = 4'(noi);
    dmc_in      = 7'(dmc);
  endtask

  initial begin
    int fi, viol;
    reset = 1'b1;
    sample_en = 1'b1;
    volume = 5'd16;
    set_levels(0, 0, 0, 0);

    // 1: reset with sample_en high, then three quiet cycles
    repeat (2) begin
      @(negedge clk);
      check("rst_out", mixer_out, 0);
      check("rst_valid", mixer_valid, 0);
    end
    reset = 1'b0;
    sample_en = 1'b0;
    repeat (3) begin
      @(negedge clk);
      check("post_rst_valid", mixer_valid, 0);
    end

    check("model_pulse30", lut_p(30), 1055);
    check("model_tnd202", lut_t(202), 3040);

`ifndef APU_MIXER_HPF_EN
    // 2: pulse-only ramp up at unity target
    got_q.delete();
    set_levels(15, 0, 0, 0);
    run_samples(20);
    idle(5);
    check("ramp_count", got_q.size(), 20);
    check("ramp_v0", got_at(0), 0);
    check("ramp_v1", got_at(1), 1040);
    check("ramp_v8", got_at(8), 8432);
    check("ramp_v15", got_at(15), ((1055 * 15) / 16) * 16);
    check("ramp_settle", got_at(19), 16880);

    // 3: step down to half volume
    got_q.delete();
    volume = 5'd8;
    run_samples(12);
    idle(5);
    check("half_first", got_at(0), 16880);
    check("half_second", got_at(1), ((1055 * 15) / 16) * 16);
    check("half_settle", got_at(11), 8432);

    // 4: all channels full scale, volume above unity clamps to 16
    got_q.delete();
    volume = 5'd20;
    set_levels(15, 15, 15, 127);
    run_samples(12);
    idle(5);
    check("fullscale", got_at(11), 65520);

    // 5: reset one cycle after a capture discards it
    set_levels(15, 0, 0, 0);
    volume = 5'd16;
    got_q.delete();
    run_samples(1);
    reset = 1'b1;
    idle(1);
    reset = 1'b0;
    idle(5);
    check("killed_sample", got_q.size(), 0);
    run_samples(2);
    idle(5);
    check("restart_v0", got_at(0), 0);
    check("restart_v1", got_at(1), 1040);
`else
    // 6: step into the DC blocker after the volume ramp is complete
    set_levels(0, 0, 0, 0);
    volume = 5'd16;
    run_samples(17);
    idle(6);
    got_q.delete();
    set_levels(15, 0, 0, 0);
    run_samples(10);
    idle(6);
    fi = -1;
    for (int i = 0; i < got_q.size(); i++)
      if (fi < 0 && got_q[i] != 0) fi = i;
    check("hpf_step", got_at(fi), 16880);
    check("hpf_second", got_at(fi + 1), 16815);
    viol = 0;
    for (int i = fi + 1; i >= 1 && i < got_q.size(); i++)
      if ($signed(got_q[i]) > $signed(got_q[i - 1]) || $signed(got_q[i]) < 0) viol++;
    check("hpf_decay", viol, 0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
